// File: rtl/systolic_row_feeder_if.sv
// Row-feeder bus: tile control, upstream valid/ready vector input, skew-line output.
interface systolic_row_feeder_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 8
);
  logic              start;
  logic [LW-1:0]     tile_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N*WIDTH-1:0] lane_out;
  logic              lane_valid;
  logic              busy;
  logic              done;

  // Upstream/controller side
  modport master (
    output start, tile_len, in_valid, in_data,
    input  in_ready, lane_out, lane_valid, busy, done
  );

  // Feeder side
  modport slave (
    input  start, tile_len, in_valid, in_data,
    output in_ready, lane_out, lane_valid, busy, done
  );
endinterface

// File: rtl/systolic_row_feeder.sv
// Feeds one row vector (or zero bubble) per clock into the skew delay lines, then
// flushes the array with FLUSH zero cycles and pulses done.
module systolic_row_feeder #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 8,
  parameter int unsigned FLUSH = 7
) (
  input logic                  clk,
  input logic                  reset,
  systolic_row_feeder_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = N * WIDTH;
  localparam logic [PW:0]   QueueFull = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   QueueOne  = (PW + 1)'(1);
  localparam logic [LW-1:0] CntOne    = LW'(1);
  localparam logic [LW-1:0] FlushLast = (FLUSH == 0) ? '0 : LW'(FLUSH - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   acc_q, acc_d;
  logic [LW-1:0]   emit_q, emit_d;
  logic [LW-1:0]   flush_q, flush_d;
  logic            done_q, done_d;
  logic            done_pend_q, done_pend_d;
  logic [DW-1:0]   lane_out_q, lane_out_d;
  logic            lane_valid_q, lane_valid_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q, count_d;
  logic [DW-1:0]   mem [DEPTH];
  logic            in_ready, push, pop;

  // Handshake and pop decisions come from registered state only
  always_comb begin
    in_ready = (state_q == StStream) && (count_q != QueueFull) && (acc_q < len_q);
    push     = bus.in_valid && in_ready;
    pop      = (state_q == StStream) && (count_q != '0);
  end

  // Queue occupancy
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + QueueOne;
    end else if (!push && pop) begin
      count_d = count_q - QueueOne;
    end
  end

  // FSM next state, beat counters and registered outputs
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    acc_d        = acc_q;
    emit_d       = emit_q;
    flush_d      = flush_q;
    done_d       = done_pend_q;
    done_pend_d  = 1'b0;
    lane_out_d   = '0;
    lane_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.tile_len != '0) begin
            state_d = StStream;
            len_d   = bus.tile_len;
            acc_d   = '0;
            emit_d  = '0;
            flush_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (push) begin
          acc_d = acc_q + CntOne;
        end
        if (pop) begin
          lane_out_d   = mem[rd_ptr_q];
          lane_valid_d = 1'b1;
          emit_d       = emit_q + CntOne;
          if (emit_d == len_q) begin
            if (FLUSH == 0) begin
              // No drain: done lands the cycle after the last vector is shown
              state_d     = StIdle;
              done_pend_d = 1'b1;
            end else begin
              state_d = StDrain;
              flush_d = '0;
            end
          end
        end
      end
      StDrain: begin
        flush_d = flush_q + CntOne;
        if (flush_q == FlushLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Queue storage; contents need no reset since pointers/count gate every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  // State, counters, pointers and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      acc_q        <= '0;
      emit_q       <= '0;
      flush_q      <= '0;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      lane_out_q   <= '0;
      lane_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      emit_q       <= emit_d;
      flush_q      <= flush_d;
      done_q       <= done_d;
      done_pend_q  <= done_pend_d;
      lane_out_q   <= lane_out_d;
      lane_valid_q <= lane_valid_d;
      count_q      <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.lane_out   = lane_out_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Randomized bench for systolic_row_feeder against a queue-based tile model.
module tb_systolic_row_feeder;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 8;
  localparam int unsigned FLUSH = 7;

  logic clk;
  logic reset;

  systolic_row_feeder_if #(.N(N), .WIDTH(WIDTH), .LW(LW)) bus ();

  systolic_row_feeder #(
    .N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW), .FLUSH(FLUSH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Tile-level model: vectors waiting to be offered, vectors held by the feeder,
  // and how far the current tile has progressed.
  logic [31:0] src[$];
  logic [31:0] q[$];
  bit          m_active;
  bit          m_pend;
  int          m_len, m_acc, m_emit, m_flush_left;
  logic [31:0] exp_lane;
  bit          exp_valid, exp_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit model_ready();
    return m_active && (m_emit < m_len) && (q.size() < DEPTH) && (m_acc < m_len);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 0; m_pend = 0;
    m_len = 0; m_acc = 0; m_emit = 0; m_flush_left = 0;
    exp_lane = '0; exp_valid = 0; exp_done = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied
  task automatic model_step();
    bit          push;
    logic [31:0] nl, tmp;
    bit          nv, nd;
    push = bus.in_valid && model_ready();
    nd = m_pend; m_pend = 0; nl = '0; nv = 0;
    if (!m_active) begin
      if (bus.start) begin
        if (bus.tile_len != 0) begin
          m_active = 1; m_len = int'(bus.tile_len); m_acc = 0; m_emit = 0;
        end else begin
          nd = 1;
        end
      end
    end else if (m_emit < m_len) begin
      if (q.size() > 0) begin
        nl = q.pop_front(); nv = 1; m_emit++;
        if (m_emit == m_len) begin
          if (FLUSH == 0) begin m_active = 0; m_pend = 1; end
          else m_flush_left = FLUSH;
        end
      end
      if (push) begin
        q.push_back(bus.in_data); m_acc++;
        if (src.size() > 0) tmp = src.pop_front();
      end
    end else begin
      m_flush_left--;
      if (m_flush_left == 0) begin m_active = 0; nd = 1; end
    end
    exp_lane = nl; exp_valid = nv; exp_done = nd;
  endtask

  task automatic compare_all();
    chk("lane_out",   64'(bus.lane_out),   64'(exp_lane));
    chk("lane_valid", 64'(bus.lane_valid), 64'(exp_valid));
    chk("in_ready",   64'(bus.in_ready),   64'(model_ready()));
    chk("busy",       64'(bus.busy),       64'(m_active));
    chk("done",       64'(bus.done),       64'(exp_done));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Start a tile and stream it; stray start pulses (tile_len=5) hit a busy feeder
  task automatic run_tile(input int len, input int pct, input int abort_after);
    int c;
    bus.start = 1'b1; bus.tile_len = LW'(len); bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (m_active && (abort_after == 0 || c < abort_after) && c < 400) begin
      bus.in_valid = ($urandom_range(99) < pct);
      bus.in_data  = (bus.in_valid && src.size() > 0) ? src[0] : $urandom;
      bus.start    = ($urandom_range(5) == 0);
      bus.tile_len = LW'(5);
      tick();
      c++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    if (abort_after == 0) chk("tile_end_busy", 64'(bus.busy), 64'(0));
  endtask

  task automatic fill_random(input int len);
    src.delete();
    for (int i = 0; i < len; i++) src.push_back($urandom);
  endtask

  // Reset a tile mid-stream: everything clears at once and no done appears
  task automatic reset_mid();
    fill_random(8);
    run_tile(8, 100, 4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    src.delete();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.tile_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;
    tick();

    // Basic tile with the reference vectors, valid held high
    src.delete();
    src.push_back(32'h04030201);
    src.push_back(32'h08070605);
    src.push_back(32'h0C0B0A09);
    run_tile(3, 100, 0);
    tick();

    // Longer tile at full rate, sparse two-vector tile, zero-length tile
    fill_random(8);
    run_tile(8, 100, 0);
    fill_random(2);
    run_tile(2, 30, 0);
    src.delete();
    run_tile(0, 100, 0);
    tick();

    reset_mid();

    for (int t = 0; t < 30; t++) begin
      int len;
      len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 14));
      fill_random(len);
      run_tile(len, int'($urandom_range(20, 100)), 0);
      if ($urandom_range(3) == 0) tick();
      if (t == 12) reset_mid();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
